// File: rtl/arc4_param.sv
// ARC4 decryptor for length-prefixed messages with an internal 256x8 S array.
// Define ARC4_EARLY_ABORT_EN to stop decrypting at the first non-printable byte.
module arc4_param #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren,
  output logic                   pt_ok
);

`ifdef ARC4_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, INIT, KSA, PRGA_LEN, PRGA, DONE
  } state_t;

  state_t                 state;
  logic [2:0]             step;
  logic [7:0]             i, j, si, sj, s_q, len;
  logic [3:0]             kidx;
  logic [8*KEY_BYTES-1:0] key_r;
  logic                   ok_r;
  logic [7:0]             s_mem [256];

  logic [7:0] key_byte, i_nx, j_ksa, j_prga;
  logic [7:0] pad_idx, pt_byte;
  logic       in_range;

  always_comb begin
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == 4'(b))
        key_byte = key_r[8*(KEY_BYTES-b)-1 -: 8];
    i_nx     = i + 8'd1;
    j_ksa    = j + s_q + key_byte;
    j_prga   = j + s_q;
    pad_idx  = si + sj;
    pt_byte  = s_q ^ ct_rddata;
    in_range = (pt_byte >= 8'h20) && (pt_byte <= 8'h7E);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 3'd0;
      rdy       <= 1'b1;
      pt_wren   <= 1'b0;
      pt_ok     <= 1'b0;
      ct_addr   <= 8'h00;
      pt_addr   <= 8'h00;
      pt_wrdata <= 8'h00;
      i         <= 8'h00;
      j         <= 8'h00;
      si        <= 8'h00;
      sj        <= 8'h00;
      s_q       <= 8'h00;
      len       <= 8'h00;
      kidx      <= 4'd0;
      key_r     <= '0;
      ok_r      <= 1'b0;
    end else begin
      pt_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && rdy) begin
            key_r <= key;
            rdy   <= 1'b0;
            pt_ok <= 1'b0;
            ok_r  <= 1'b1;
            i     <= 8'h00;
            j     <= 8'h00;
            state <= INIT;
          end
        end
        INIT: begin
          s_mem[i] <= i;
          i        <= i_nx;
          if (i == 8'hFF) begin
            state <= KSA;
            step  <= 3'd0;
            kidx  <= 4'd0;
          end
        end
        KSA: begin
          case (step)
            3'd0: begin
              s_q  <= s_mem[i];
              step <= 3'd1;
            end
            3'd1: begin
              si   <= s_q;
              j    <= j_ksa;
              s_q  <= s_mem[j_ksa];
              step <= 3'd2;
            end
            3'd2: begin
              s_mem[i] <= s_q;
              step     <= 3'd3;
            end
            default: begin
              s_mem[j] <= si;
              i        <= i_nx;
              step     <= 3'd0;
              if (kidx == 4'(KEY_BYTES-1))
                kidx <= 4'd0;
              else
                kidx <= kidx + 4'd1;
              if (i == 8'hFF) begin
                state   <= PRGA_LEN;
                j       <= 8'h00;
                ct_addr <= 8'h00;
              end
            end
          endcase
        end
        PRGA_LEN: begin
          // ct_addr was set on KSA exit; the ROM needs one cycle.
          if (step == 3'd0) begin
            step <= 3'd1;
          end else begin
            len       <= ct_rddata;
            pt_addr   <= 8'h00;
            pt_wrdata <= ct_rddata;
            pt_wren   <= 1'b1;
            step      <= 3'd0;
            if (ct_rddata == 8'h00) begin
              state <= DONE;
            end else begin
              state   <= PRGA;
              ct_addr <= 8'h01;
            end
          end
        end
        PRGA: begin
          case (step)
            3'd0: begin
              i    <= i_nx;
              s_q  <= s_mem[i_nx];
              step <= 3'd1;
            end
            3'd1: begin
              si   <= s_q;
              j    <= j_prga;
              s_q  <= s_mem[j_prga];
              step <= 3'd2;
            end
            3'd2: begin
              sj       <= s_q;
              s_mem[i] <= s_q;
              step     <= 3'd3;
            end
            3'd3: begin
              s_mem[j] <= si;
              step     <= 3'd4;
            end
            3'd4: begin
              s_q  <= s_mem[pad_idx];
              step <= 3'd5;
            end
            default: begin
              pt_addr   <= ct_addr;
              pt_wrdata <= pt_byte;
              pt_wren   <= 1'b1;
              step      <= 3'd0;
              if (!in_range)
                ok_r <= 1'b0;
              if (ct_addr == len || (EARLY_ABORT && !in_range))
                state <= DONE;
              else
                ct_addr <= ct_addr + 8'd1;
            end
          endcase
        end
        DONE: begin
          pt_ok <= ok_r;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_param.sv
// Directed bench for arc4_param: known RC4 vectors, len=0, ignored en,
// mid-run reset and the non-printable byte case.
module tb_arc4_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en3, en4, clr;
  logic [23:0] key3;
  logic [31:0] key4;
  logic        rdy3, rdy4;
  logic [7:0]  ct_addr3, ct_addr4, ct_rd3, ct_rd4;
  logic [7:0]  pt_addr3, pt_addr4, pt_wd3, pt_wd4;
  logic        pt_wren3, pt_wren4, pt_ok3, pt_ok4;

  logic [7:0]  ct_mem [256];
  logic [7:0]  pt_mem [256];
  int          wr_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  arc4_param #(.KEY_BYTES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .rdy(rdy3), .key(key3),
    .ct_addr(ct_addr3), .ct_rddata(ct_rd3),
    .pt_addr(pt_addr3), .pt_wrdata(pt_wd3),
    .pt_wren(pt_wren3), .pt_ok(pt_ok3)
  );

  arc4_param #(.KEY_BYTES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .rdy(rdy4), .key(key4),
    .ct_addr(ct_addr4), .ct_rddata(ct_rd4),
    .pt_addr(pt_addr4), .pt_wrdata(pt_wd4),
    .pt_wren(pt_wren4), .pt_ok(pt_ok4)
  );

  always @(posedge clk) begin
    ct_rd3 <= ct_mem[ct_addr3];
    ct_rd4 <= ct_mem[ct_addr4];
    if (clr) begin
      wr_cnt <= 0;
      for (int a = 0; a < 256; a++) pt_mem[a] <= 8'hEE;
    end else begin
      if (pt_wren3) pt_mem[pt_addr3] <= pt_wd3;
      if (pt_wren4) pt_mem[pt_addr4] <= pt_wd4;
      wr_cnt <= wr_cnt + int'(pt_wren3) + int'(pt_wren4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [79:0] v, input int n);
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    for (int k = 0; k < n; k++) ct_mem[k] = v[8*(n-k)-1 -: 8];
  endtask

  task automatic clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic start(input bit four, input string tag);
    @(negedge clk);
    if (four) en4 = 1'b1;
    else      en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0;
    en4 = 1'b0;
    chk({tag, "_rdy_low"}, four ? rdy4 : rdy3, 1'b0);
    chk({tag, "_ok_clr"}, four ? pt_ok4 : pt_ok3, 1'b0);
  endtask

  task automatic wait_rdy(input bit four, input string tag);
    int n = 0;
    while ((four ? rdy4 : rdy3) !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < 6000), 1);
    @(negedge clk);
  endtask

  task automatic check_plain(input string tag);
    string s = "Plaintext";
    chk({tag, "_len"}, pt_mem[0], 8'h09);
    for (int k = 1; k <= 9; k++)
      chk($sformatf("%s_pt%0d", tag, k), pt_mem[k], s[k-1]);
    chk({tag, "_ok"}, pt_ok3, 1'b1);
    chk({tag, "_writes"}, wr_cnt, 10);
    chk({tag, "_rdy"}, rdy3, 1'b1);
  endtask

  // Plain software RC4, used only to build the vector with a control byte.
  function automatic logic [7:0] rc4_ks(input logic [23:0] k, input int n);
    logic [7:0] s [256];
    int ii, jj, t, r;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(s[a]) + int'(k[8*(2-a%3) +: 8])) % 256;
      t = int'(s[a]); s[a] = s[jj]; s[jj] = 8'(t);
    end
    ii = 0; jj = 0; r = 0;
    for (int m = 0; m < n; m++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      t = int'(s[ii]); s[ii] = s[jj]; s[jj] = 8'(t);
      r = (int'(s[ii]) + int'(s[jj])) % 256;
    end
    return s[r];
  endfunction

  initial begin
    logic [7:0] want [9];
    int c;
    rst_n = 1'b0;
    en3   = 1'b1;
    en4   = 1'b0;
    clr   = 1'b0;
    key3  = 24'h4B6579;
    key4  = 32'h57696B69;
    load(80'h09BBF316E8D940AF0AD3, 10);
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy3, 1'b1);
    chk("rst_wren", pt_wren3, 1'b0);
    chk("rst_ok", pt_ok3, 1'b0);
    chk("rst_ct_addr", ct_addr3, 8'h00);
    chk("rst_pt_addr", pt_addr3, 8'h00);
    chk("rst_pt_wrdata", pt_wd3, 8'h00);
    rst_n = 1'b1;
    en3   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en_ignored", rdy3, 1'b1);

    clear();
    start(1'b0, "key");
    wait_rdy(1'b0, "key");
    check_plain("key");

    clear();
    start(1'b0, "reen");
    repeat (600) @(negedge clk);
    key3 = 24'h112233;
    en3  = 1'b1;
    @(negedge clk);
    en3  = 1'b0;
    wait_rdy(1'b0, "reen");
    check_plain("reen");
    key3 = 24'h4B6579;

    load(80'h051021BF0420, 6);
    clear();
    start(1'b1, "wiki");
    wait_rdy(1'b1, "wiki");
    chk("wiki_len", pt_mem[0], 8'h05);
    chk("wiki_p", pt_mem[1], "p");
    chk("wiki_e", pt_mem[2], "e");
    chk("wiki_d", pt_mem[3], "d");
    chk("wiki_i", pt_mem[4], "i");
    chk("wiki_a", pt_mem[5], "a");
    chk("wiki_ok", pt_ok4, 1'b1);
    chk("wiki_writes", wr_cnt, 6);

    load(80'h00, 1);
    ct_mem[1] = 8'h55;
    clear();
    start(1'b0, "zero");
    wait_rdy(1'b0, "zero");
    chk("zero_len", pt_mem[0], 8'h00);
    chk("zero_untouched", pt_mem[1], 8'hEE);
    chk("zero_writes", wr_cnt, 1);
    chk("zero_ok", pt_ok3, 1'b1);

    load(80'h09BBF316E8D940AF0AD3, 10);
    clear();
    start(1'b0, "abort");
    c = 0;
    while (wr_cnt < 3 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("abort_in_prga", 32'(c < 3000), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rdy", rdy3, 1'b1);
    chk("abort_wren", pt_wren3, 1'b0);
    c = wr_cnt;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_writes", wr_cnt, c);
    clear();
    start(1'b0, "fresh");
    wait_rdy(1'b0, "fresh");
    check_plain("fresh");

    want[1] = "a"; want[2] = "b"; want[3] = 8'h01; want[4] = "d";
    want[5] = "e"; want[6] = "f"; want[7] = "g"; want[8] = "h";
    load(80'h08, 1);
    for (int k = 1; k <= 8; k++) ct_mem[k] = rc4_ks(24'h0, k) ^ want[k];
    key3 = 24'h000000;
    clear();
    start(1'b0, "ctl");
    wait_rdy(1'b0, "ctl");
    chk("ctl_len", pt_mem[0], 8'h08);
    chk("ctl_pt1", pt_mem[1], "a");
    chk("ctl_pt3", pt_mem[3], 8'h01);
    chk("ctl_ok", pt_ok3, 1'b0);
`ifdef ARC4_EARLY_ABORT_EN
    chk("ctl_writes", wr_cnt, 4);
    chk("ctl_pt4", pt_mem[4], 8'hEE);
`else
    chk("ctl_writes", wr_cnt, 9);
    chk("ctl_pt4", pt_mem[4], "d");
    chk("ctl_pt8", pt_mem[8], "h");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_param.md
ARC4_PARAM -- requirements
Module: arc4_param

Interface
REQ-001 KEY_BYTES, default 3, key length in bytes, legal range 1..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  start request; sampled only while rdy=1.
REQ-005 rdy  output  1  idle/ready; high when a new en is accepted.
REQ-006 key  input  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first).
REQ-007 ct_addr  output  8  ciphertext memory address.
REQ-008 ct_rddata  input  8  ciphertext data, valid 1 cycle after ct_addr (synchronous ROM).
REQ-009 pt_addr  output  8  plaintext memory address.
REQ-010 pt_wrdata  output  8  plaintext write data.
REQ-011 pt_wren  output  1  plaintext write strobe, 1-cycle pulse per byte.
REQ-012 pt_ok  output  1  high when every decrypted byte 1..len lies in 0x20..0x7E; valid while rdy=1 after a run.

Function
REQ-013 Internal 256x8 S array, synchronous read with 1-cycle latency, one access (read or write) per cycle; no external S port.
REQ-014 Message format is length-prefixed: ct[0] = len (0..255), ct[1..len] = ciphertext; pt[0] = len, pt[1..len] = plaintext.
REQ-015 en with rdy=1 latches key, drives rdy low on the next cycle, and leaves IDLE; en while rdy=0 is ignored; key changes after acceptance have no effect.
REQ-016 States: IDLE -> INIT -> KSA -> PRGA_LEN -> PRGA -> DONE -> IDLE.
REQ-017 INIT: S[i]=i for i=0..255, one write per cycle, 256 cycles.
REQ-018 KSA: for i=0..255, j=(j+S[i]+key_byte[i mod KEY_BYTES]) mod 256, swap S[i],S[j]; j starts at 0; at most 6 cycles per iteration.
REQ-019 i mod KEY_BYTES uses a wrapping counter 0..KEY_BYTES-1 (no divider).
REQ-020 PRGA_LEN: read ct[0], write pt[0]=len with one pt_wren pulse.
REQ-021 PRGA: for k=1..len: i=i+1, j=j+S[i], swap, pad=S[(S[i]+S[j]) mod 256], pt[k]=pad^ct[k]; i,j start at 0; all sums mod 256; at most 8 cycles per byte.
REQ-022 len=0: only pt[0]=0 written; PRGA skipped; pt_ok=1.
REQ-023 len=255: last write at pt_addr=0xFF; no address wrap to 0.
REQ-024 pt_ok is cleared at start and falls to 0 permanently on the first out-of-range byte.
REQ-025 DONE lasts one cycle; rdy rises on the cycle after DONE and stays high until the next accepted en.
REQ-026 pt_wren is low in every state except the byte-write cycles.

Reset
REQ-027 On rst_n=0 at a clock edge: state=IDLE, rdy=1, pt_wren=0, pt_ok=0, ct_addr=0, pt_addr=0, pt_wrdata=0, i=j=0.
REQ-028 Reset mid-run aborts with no further pt writes; S contents are undefined until the next INIT.
REQ-029 en asserted during reset is ignored.

Configuration
REQ-030 Macro ARC4_EARLY_ABORT_EN defined: on the first out-of-range byte, that byte is still written, pt_ok=0, remaining bytes are skipped, and the next state is DONE.
REQ-031 Macro ARC4_EARLY_ABORT_EN undefined: all len bytes are always decrypted and written regardless of pt_ok.

Verification
REQ-032 KEY_BYTES=3, key=0x4B6579, ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> pt={09,"Plaintext"}, pt_ok=1, 10 pt_wren pulses, rdy returns high.
REQ-033 KEY_BYTES=4, key=0x57696B69, ct={05,10,21,BF,04,20} -> pt={05,"pedia"}, pt_ok=1.
REQ-034 ct[0]=0x00 -> exactly one write pt[0]=00, pt_ok=1, rdy high after DONE.
REQ-035 en pulsed again mid-KSA with a different key -> ignored; REQ-032 output is unchanged.
REQ-036 rst_n low during PRGA -> next cycle rdy=1, pt_wren=0; a fresh REQ-032 run then passes.
REQ-037 key=0x000000, ct={08, eight bytes whose decryption has pt[3]=0x01} -> with ARC4_EARLY_ABORT_EN: writes stop at pt[3], pt_ok=0; without it: 9 writes, pt_ok=0.
